// File: rtl/volume_cmd_arbiter.sv
// volume_cmd_arbiter: two-requester round-robin arbiter that converts the
// granted requester's held volume key into single-cycle step strobes with
// press-and-hold auto-repeat.
//
// Build option: define VOLCTRL_AUTOREPEAT_EN to enable auto-repeat.
// Undefined (default), the REPEAT state and the delay counter are removed
// and every press yields exactly one step.
module volume_cmd_arbiter #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CNT_W         = 32
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic A_UP,
  input  logic A_DOWN,
  input  logic B_UP,
  input  logic B_DOWN,
  output logic VOLUP,
  output logic VOLDOWN,
  output logic VOLVALID,
  output logic GRANT_A,
  output logic GRANT_B
);

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DOWN = 2'b10
  } cmd_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DELAY  = 2'b01,
    S_REPEAT = 2'b10
  } state_t;

  // Reject parameter values that would make the counter compare unreachable.
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || CNT_W < 1) begin : g_bad_param
    $error("volume_cmd_arbiter: REPEAT_DELAY, REPEAT_PERIOD and CNT_W must be >= 1");
  end

  // Both keys or no key of one requester is treated as no request at all.
  function automatic cmd_t decode(input logic up, input logic down);
    case ({up, down})
      2'b10:   decode = CMD_UP;
      2'b01:   decode = CMD_DOWN;
      default: decode = CMD_NONE;
    endcase
  endfunction

  state_t r_state;
  owner_t r_owner;
  owner_t r_last_owner;
  cmd_t   r_dir;
  logic   r_volup;
  logic   r_voldown;
  logic   r_volvalid;
  logic   r_grant_a;
  logic   r_grant_b;

  state_t w_state_nxt;
  owner_t w_owner_nxt;
  owner_t w_last_owner_nxt;
  cmd_t   w_dir_nxt;
  logic   w_step;
  cmd_t   w_cmd_a;
  cmd_t   w_cmd_b;
  cmd_t   w_cmd_own;

`ifdef VOLCTRL_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
`endif

  assign w_cmd_a   = decode(A_UP, A_DOWN);
  assign w_cmd_b   = decode(B_UP, B_DOWN);
  // Only the owner's keys matter once a grant is held.
  assign w_cmd_own = (r_owner == OWN_A) ? w_cmd_a : w_cmd_b;

  // Next-state, arbitration and step decision.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_dir_nxt        = r_dir;
    w_step           = 1'b0;
`ifdef VOLCTRL_AUTOREPEAT_EN
    w_cnt_nxt        = r_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_cmd_a != CMD_NONE || w_cmd_b != CMD_NONE) begin
          // A wins when B is silent, or on a tie when B was served last.
          if (w_cmd_a != CMD_NONE && (w_cmd_b == CMD_NONE || r_last_owner == OWN_B)) begin
            w_owner_nxt = OWN_A;
            w_dir_nxt   = w_cmd_a;
          end else begin
            w_owner_nxt = OWN_B;
            w_dir_nxt   = w_cmd_b;
          end
          w_last_owner_nxt = w_owner_nxt;
          w_step           = 1'b1;
          w_state_nxt      = S_DELAY;
`ifdef VOLCTRL_AUTOREPEAT_EN
          w_cnt_nxt        = '0;
`endif
        end
      end

      S_DELAY: begin
        if (w_cmd_own != r_dir) begin
          w_state_nxt = S_IDLE;
`ifdef VOLCTRL_AUTOREPEAT_EN
        end else if (r_cnt == DELAY_LAST) begin
          w_step      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
`endif
        end
      end

`ifdef VOLCTRL_AUTOREPEAT_EN
      S_REPEAT: begin
        if (w_cmd_own != r_dir) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == PERIOD_LAST) begin
          w_step    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
`endif

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM and arbitration state register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_A;
      r_last_owner <= OWN_B;
      r_dir        <= CMD_NONE;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample the
      // pre-edge values, independent of statement order.
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_dir        <= w_dir_nxt;
    end
  end

`ifdef VOLCTRL_AUTOREPEAT_EN
  // Cycle counter for the first-repeat delay and the repeat period.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`endif

  // Registered outputs: the step strobe lives for exactly one cycle and
  // grants follow the next state, so neither glitches with input changes.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_volvalid <= 1'b0;
      r_volup    <= 1'b0;
      r_voldown  <= 1'b0;
      r_grant_a  <= 1'b0;
      r_grant_b  <= 1'b0;
    end else begin
      r_volvalid <= w_step;
      r_volup    <= w_step && (w_dir_nxt == CMD_UP);
      r_voldown  <= w_step && (w_dir_nxt == CMD_DOWN);
      r_grant_a  <= (w_state_nxt != S_IDLE) && (w_owner_nxt == OWN_A);
      r_grant_b  <= (w_state_nxt != S_IDLE) && (w_owner_nxt == OWN_B);
    end
  end

  assign VOLVALID = r_volvalid;
  assign VOLUP    = r_volup;
  assign VOLDOWN  = r_voldown;
  assign GRANT_A  = r_grant_a;
  assign GRANT_B  = r_grant_b;

endmodule

// File: tb/tb_volume_cmd_arbiter.sv
// tb_volume_cmd_arbiter: directed bench for volume_cmd_arbiter with
// REPEAT_DELAY = 8 and REPEAT_PERIOD = 3. Expected pulse positions follow
// the auto-repeat setting selected by VOLCTRL_AUTOREPEAT_EN.
module tb_volume_cmd_arbiter;

  localparam int D = 8;
  localparam int P = 3;
`ifdef VOLCTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  // Output vector order: {VOLVALID, VOLUP, VOLDOWN, GRANT_A, GRANT_B}
  localparam logic [4:0] Z      = 5'b00000;
  localparam logic [4:0] A_STEP = 5'b11010;
  localparam logic [4:0] A_HOLD = 5'b00010;
  localparam logic [4:0] B_DN   = 5'b10101;
  localparam logic [4:0] B_HOLD = 5'b00001;

  logic CLK = 1'b0;
  logic RESETn;
  logic A_UP, A_DOWN, B_UP, B_DOWN;
  logic VOLUP, VOLDOWN, VOLVALID, GRANT_A, GRANT_B;

  int total = 0;
  int bad   = 0;

  volume_cmd_arbiter #(
    .REPEAT_DELAY (D),
    .REPEAT_PERIOD(P),
    .CNT_W        (4)
  ) dut (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .A_UP    (A_UP),
    .A_DOWN  (A_DOWN),
    .B_UP    (B_UP),
    .B_DOWN  (B_DOWN),
    .VOLUP   (VOLUP),
    .VOLDOWN (VOLDOWN),
    .VOLVALID(VOLVALID),
    .GRANT_A (GRANT_A),
    .GRANT_B (GRANT_B)
  );

  always #5 CLK = ~CLK;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: sequence did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] outs();
    return {VOLVALID, VOLUP, VOLDOWN, GRANT_A, GRANT_B};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Outputs are sampled mid-cycle; inputs change right after sampling.
  task automatic tick();
    @(negedge CLK);
  endtask

  // A step is expected at cycle 0 of a hold and, with auto-repeat, at
  // D, D+P, D+2P, ...
  function automatic bit pulse_at(input int c);
    return (c == 0) || (AR && c >= D && ((c - D) % P) == 0);
  endfunction

  function automatic logic [4:0] hold_vec(input int c, input bit up, input bit own_a);
    bit p;
    p = pulse_at(c);
    return {p, p & up, p & ~up, own_a, ~own_a};
  endfunction

  // Check cycles [first, last] of a hold whose first step is cycle 0.
  task automatic hold_check(input string tag, input int first, input int last,
                            input bit up, input bit own_a);
    for (int c = first; c <= last; c++) begin
      tick();
      check($sformatf("%s[%0d]", tag, c), outs(), hold_vec(c, up, own_a));
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s[%0d]", tag, i), outs(), Z);
    end
  endtask

  initial begin
    // Reset held with A_UP pressed: everything stays low.
    RESETn = 1'b0;
    A_UP = 1'b1; A_DOWN = 1'b0; B_UP = 1'b0; B_DOWN = 1'b0;
    idle_check("reset_hold", 3);

    // Release reset; first sampling edge grants A, then hold for 20 cycles.
    RESETn = 1'b1;
    hold_check("a_up_hold", 0, 19, 1'b1, 1'b1);
    // Release lands on the edge that would have produced cycle 20's step.
    A_UP = 1'b0;
    idle_check("a_up_release", 3);

    // Tie straight after reset: A wins, B waits silently.
    RESETn = 1'b0;
    A_UP = 1'b1; B_DOWN = 1'b1;
    tick();
    check("tie_in_reset", outs(), Z);
    RESETn = 1'b1;
    tick();
    check("tie1_a_wins", outs(), A_STEP);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("tie1_b_waits[%0d]", i), outs(), A_HOLD);
    end
    // A lets go: one IDLE cycle, then B is granted with a down step.
    A_UP = 1'b0;
    tick();
    check("a_drop_idle", outs(), Z);
    tick();
    check("b_granted", outs(), B_DN);
    tick();
    check("b_hold1", outs(), B_HOLD);
    tick();
    check("b_hold2", outs(), B_HOLD);
    B_DOWN = 1'b0;
    idle_check("b_release", 2);

    // Make A the last owner, then tie again: B wins by round robin.
    A_UP = 1'b1;
    tick();
    check("a_single", outs(), A_STEP);
    A_UP = 1'b0;
    idle_check("a_single_release", 2);
    A_UP = 1'b1; B_DOWN = 1'b1;
    tick();
    check("tie2_b_wins", outs(), B_DN);
    tick();
    check("tie2_a_ignored", outs(), B_HOLD);
    A_UP = 1'b0; B_DOWN = 1'b0;
    idle_check("tie2_release", 2);
    // B was last: the next tie goes to A.
    A_UP = 1'b1; B_DOWN = 1'b1;
    tick();
    check("tie3_a_wins", outs(), A_STEP);
    A_UP = 1'b0; B_DOWN = 1'b0;
    idle_check("tie3_release", 2);

    // A holds up, then adds down at cycle 4: grant drops, both-pressed
    // is never granted, and no step appears at the would-be repeat.
    A_UP = 1'b1;
    hold_check("a_both", 0, 3, 1'b1, 1'b1);
    A_DOWN = 1'b1;
    idle_check("a_both_pressed", 7);
    A_UP = 1'b0; A_DOWN = 1'b0;
    idle_check("a_both_release", 1);

    // Reset at cycle 7 of a hold: immediate clear, nothing at cycle 8.
    A_UP = 1'b1;
    hold_check("pre_reset", 0, 7, 1'b1, 1'b1);
    RESETn = 1'b0;
    #1;
    check("reset_async", outs(), Z);
    idle_check("reset_mid_hold", 3);
    RESETn = 1'b1;
    tick();
    check("after_reset_step", outs(), A_STEP);
    A_UP = 1'b0;
    idle_check("after_reset_release", 1);

    // Hold A_DOWN 30 cycles, release, then one re-press.
    A_DOWN = 1'b1;
    hold_check("a_down_hold", 0, 29, 1'b0, 1'b1);
    A_DOWN = 1'b0;
    idle_check("a_down_release", 2);
    A_DOWN = 1'b1;
    hold_check("a_down_repress", 0, 4, 1'b0, 1'b1);
    A_DOWN = 1'b0;
    idle_check("a_down_final", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
